// File: rtl/frame_uart_sched.sv
// Frame drain sequencer: pulls one frame of 16-bit words from the sample FIFO,
// serialises each word MSB-first to the UART and optionally appends an 8-bit sum.
module frame_uart_sched #(
  parameter int FRAME_WORDS = 721,
  parameter int TIMEOUT_CYC = 2000000,
  parameter bit CHK_EN      = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        start_send,
  input  logic        fifo_rdempty,
  input  logic [15:0] fifo_q,
  output logic        fifo_rdreq,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        err_underrun,
  output logic        err_overlap
);

  localparam int WCW = $clog2(FRAME_WORDS + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    LATCH,
    SEND_HI,
    SEND_LO,
    SEND_CHK,
    DONE
  } state_t;

  state_t         state_reg;
  logic [WCW-1:0] word_cnt_reg;
  logic [TCW-1:0] tmo_cnt_reg;
  logic [7:0]     chk_reg;
  logic [7:0]     word_lo_reg;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg    <= IDLE;
      word_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      chk_reg      <= '0;
      word_lo_reg  <= '0;
      fifo_rdreq   <= 1'b0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      err_underrun <= 1'b0;
      err_overlap  <= 1'b0;
    end else begin
      fifo_rdreq   <= 1'b0;
      frame_done   <= 1'b0;
      err_underrun <= 1'b0;

      // A start arriving while busy, or in the cycle the abort pulse is out, is rejected
      if (start_send && (busy || err_underrun))
        err_overlap <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (start_send && !err_underrun) begin
            state_reg    <= RD_REQ;
            busy         <= 1'b1;
            word_cnt_reg <= '0;
            chk_reg      <= '0;
            tmo_cnt_reg  <= '0;
            err_overlap  <= 1'b0;
          end
        end

        RD_REQ: begin
          if (!fifo_rdempty) begin
            fifo_rdreq  <= 1'b1;
            tmo_cnt_reg <= '0;
            state_reg   <= RD_WAIT;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            err_underrun <= 1'b1;
            busy         <= 1'b0;
            tmo_cnt_reg  <= '0;
            state_reg    <= IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TCW'(1);
          end
        end

        // fifo_rdreq is high during this cycle; read data lands after the next edge
        RD_WAIT: state_reg <= LATCH;

        LATCH: begin
          word_lo_reg <= fifo_q[7:0];
          tx_data     <= fifo_q[15:8];
          tx_valid    <= 1'b1;
          state_reg   <= SEND_HI;
        end

        SEND_HI: begin
          if (tx_ready) begin
            chk_reg   <= chk_reg + tx_data;
            tx_data   <= word_lo_reg;
            state_reg <= SEND_LO;
          end
        end

        SEND_LO: begin
          if (tx_ready) begin
            chk_reg      <= chk_reg + tx_data;
            word_cnt_reg <= word_cnt_reg + WCW'(1);
            if (word_cnt_reg == LAST_WORD) begin
              if (CHK_EN) begin
                tx_data   <= chk_reg + tx_data;
                state_reg <= SEND_CHK;
              end else begin
                tx_valid   <= 1'b0;
                frame_done <= 1'b1;
                state_reg  <= DONE;
              end
            end else begin
              tx_valid  <= 1'b0;
              state_reg <= RD_REQ;
            end
          end
        end

        SEND_CHK: begin
          if (tx_ready) begin
            tx_valid   <= 1'b0;
            frame_done <= 1'b1;
            state_reg  <= DONE;
          end
        end

        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_uart_sched.sv
// Directed bench for frame_uart_sched: behavioural FIFO in front, byte sink behind,
// frames checked byte-for-byte against the words the bench itself loaded.
module tb_frame_uart_sched;

  localparam int FW = 721;
  localparam int TO = 2000;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        start_send = 1'b0;
  logic        tx_ready = 1'b0;
  logic        fifo_rdempty;
  logic        fifo_rdreq;
  logic [15:0] fifo_q = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        frame_done;
  logic        err_underrun;
  logic        err_overlap;

  int checks = 0;
  int failures = 0;

  frame_uart_sched #(.FRAME_WORDS(FW), .TIMEOUT_CYC(TO), .CHK_EN(1'b1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .start_send(start_send), .fifo_rdempty(fifo_rdempty),
    .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done),
    .err_underrun(err_underrun), .err_overlap(err_overlap)
  );

  always #5 Clk = ~Clk;

  // Normal-mode FIFO: q updates the edge after a sampled read request
  logic [15:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_rdempty = (rd_ptr == wr_ptr);
  always @(posedge Clk)
    if (fifo_rdreq && rd_ptr != wr_ptr) begin
      fifo_q <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end

  // Sink monitor, sampled mid-cycle on the falling edge
  logic [7:0] bytes [$];
  int cyc = 0, rd_cnt = 0, viol = 0, last_xfer_cyc = 0;
  int done_cnt = 0, done_cyc = 0, under_cnt = 0, under_cyc = 0;
  logic       held = 1'b0;
  logic [7:0] held_data = '0;
  always @(negedge Clk) begin
    cyc <= cyc + 1;
    if (tx_valid && tx_ready) begin
      bytes.push_back(tx_data);
      last_xfer_cyc <= cyc;
    end
    if (fifo_rdreq) begin
      rd_cnt <= rd_cnt + 1;
      if (fifo_rdempty) viol <= viol + 1;
    end
    if (Rst_n && held && (!tx_valid || tx_data != held_data)) viol <= viol + 1;
    held      <= Rst_n && tx_valid && !tx_ready;
    held_data <= tx_data;
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (err_underrun) begin
      under_cnt <= under_cnt + 1;
      under_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_range(input int first, input int last);
    for (int i = first; i <= last; i++)
      push((i == 0) ? 16'h7A00 : 16'(i));
  endtask

  task automatic pulse_start();
    start_send = 1'b1;
    step();
    start_send = 1'b0;
  endtask

  // Runs until frame_done or err_underrun; optionally randomises tx_ready and
  // injects one extra start_send once ovl_word words have gone out.
  task automatic run_frame(input bit rnd, input int ovl_word, input int b0, output int res);
    bit ovl_done = 1'b0;
    res = 0;
    for (int n = 0; n < 20000; n++) begin
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      if (ovl_word >= 0 && !ovl_done && (bytes.size() - b0) >= 2 * ovl_word) begin
        start_send = 1'b1;
        ovl_done   = 1'b1;
      end else begin
        start_send = 1'b0;
      end
      step();
      if (frame_done || err_underrun) begin
        res = 1;
        break;
      end
    end
    start_send = 1'b0;
    tx_ready   = 1'b1;
  endtask

  task automatic check_frame(input string tag, input int b0, input int r0, input int d0,
                             input int head);
    int nb;
    int mism;
    logic [7:0]  sum;
    logic [7:0]  cb;
    logic [15:0] w;
    nb   = bytes.size() - b0;
    mism = 0;
    sum  = '0;
    for (int k = 0; k < FW; k++) begin
      w   = mem[head + k];
      sum = 8'(sum + w[15:8] + w[7:0]);
      if (2 * k + 1 < nb) begin
        if (bytes[b0 + 2 * k] !== w[15:8]) mism++;
        if (bytes[b0 + 2 * k + 1] !== w[7:0]) mism++;
      end else begin
        mism++;
      end
    end
    cb = (nb >= 2 * FW + 1) ? bytes[b0 + 2 * FW] : ~sum;
    chk({tag, "_nbytes"}, nb, 2 * FW + 1);
    chk({tag, "_stream_mism"}, mism, 0);
    chk({tag, "_chk_byte"}, cb, sum);
    chk({tag, "_rdreq_cnt"}, rd_cnt - r0, FW);
    chk({tag, "_done_cnt"}, done_cnt - d0, 1);
    chk({tag, "_done_lat"}, done_cyc - last_xfer_cyc, 1);
    chk({tag, "_viol"}, viol, 0);
    chk({tag, "_busy_after"}, busy, 1'b0);
    chk({tag, "_done_pulse"}, frame_done, 1'b0);
  endtask

  initial begin
    int b0, r0, d0, u0, head, res, n;

    // Reset values
    repeat (3) step();
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdreq", fifo_rdreq, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_errs", {frame_done, err_underrun, err_overlap}, 3'b000);
    Rst_n = 1'b1;
    step();

    // 1: full frame, sink always ready, hand-checked bytes and checksum 0x04
    push_range(0, FW - 1);
    head = 0;
    tx_ready = 1'b1;
    b0 = bytes.size(); r0 = rd_cnt; d0 = done_cnt;
    pulse_start();
    chk("s1_busy", busy, 1'b1);
    step(); step();
    chk("s1_lat_not_yet", tx_valid, 1'b0);
    step();
    chk("s1_lat_valid", tx_valid, 1'b1);
    chk("s1_first_byte", tx_data, 8'h7A);
    run_frame(1'b0, -1, b0, res);
    chk("s1_finished", res, 1);
    step();
    check_frame("s1", b0, r0, d0, head);
    chk("s1_byte1", bytes[b0 + 1], 8'h00);
    chk("s1_byte3", bytes[b0 + 3], 8'h01);
    chk("s1_last_hi", bytes[b0 + 1440], 8'h02);
    chk("s1_last_lo", bytes[b0 + 1441], 8'hD0);
    chk("s1_chk_const", bytes[b0 + 1442], 8'h04);
    step();

    // 2: same frame with random back-pressure
    push_range(0, FW - 1);
    head = head + FW;
    b0 = bytes.size(); r0 = rd_cnt; d0 = done_cnt;
    pulse_start();
    run_frame(1'b1, -1, b0, res);
    chk("s2_finished", res, 1);
    step();
    check_frame("s2", b0, r0, d0, head);
    chk("s2_chk_const", bytes[b0 + 1442], 8'h04);
    step();

    // 3: FIFO dries up after 10 words and refills 1000 cycles later
    push_range(0, 9);
    head = head + FW;
    b0 = bytes.size(); r0 = rd_cnt; d0 = done_cnt; u0 = under_cnt;
    pulse_start();
    n = 0;
    while ((rd_cnt - r0) < 10 && n < 500) begin
      step();
      n++;
    end
    chk("s3_drained_10", rd_cnt - r0, 10);
    repeat (1000) step();
    chk("s3_still_busy", busy, 1'b1);
    push_range(10, FW - 1);
    run_frame(1'b0, -1, b0, res);
    chk("s3_finished", res, 1);
    step();
    check_frame("s3", b0, r0, d0, head);
    chk("s3_no_underrun", under_cnt - u0, 0);
    step();

    // 4: FIFO dries up after 10 words and never refills
    push_range(0, 9);
    head = head + FW;
    b0 = bytes.size(); d0 = done_cnt; u0 = under_cnt;
    pulse_start();
    run_frame(1'b0, -1, b0, res);
    chk("s4_ended", res, 1);
    chk("s4_underrun_pulse", err_underrun, 1'b1);
    chk("s4_busy_low", busy, 1'b0);
    step();
    chk("s4_underrun_cnt", under_cnt - u0, 1);
    chk("s4_timeout_dist", under_cyc - last_xfer_cyc, TO + 1);
    chk("s4_nbytes", bytes.size() - b0, 20);
    chk("s4_no_done", done_cnt - d0, 0);
    chk("s4_pulse_end", err_underrun, 1'b0);
    step();

    // 5: second start_send at word 300 flags overlap but leaves the frame intact
    push_range(0, FW - 1);
    head = head + 10;
    b0 = bytes.size(); r0 = rd_cnt; d0 = done_cnt;
    pulse_start();
    chk("s5_overlap_clear", err_overlap, 1'b0);
    run_frame(1'b0, 300, b0, res);
    chk("s5_finished", res, 1);
    step();
    check_frame("s5", b0, r0, d0, head);
    chk("s5_overlap_set", err_overlap, 1'b1);
    step();
    push_range(0, FW - 1);
    head = head + FW;
    b0 = bytes.size();
    pulse_start();
    chk("s5_overlap_cleared", err_overlap, 1'b0);
    chk("s5_restart_busy", busy, 1'b1);

    // 6: reset while holding the low byte of word 5, then a clean frame from the FIFO head
    n = 0;
    while ((bytes.size() - b0) < 11 && n < 500) begin
      step();
      n++;
    end
    tx_ready = 1'b0;
    chk("s6_at_send_lo", bytes.size() - b0, 11);
    step();
    chk("s6_holding", tx_valid, 1'b1);
    chk("s6_held_lo", tx_data, 8'h05);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("s6_async_valid", tx_valid, 1'b0);
    chk("s6_async_busy", busy, 1'b0);
    chk("s6_async_data", tx_data, 8'h00);
    chk("s6_async_rest", {fifo_rdreq, frame_done, err_underrun, err_overlap}, 4'b0000);
    repeat (2) step();
    Rst_n = 1'b1;
    step();
    head = head + 6;
    push(16'hA5A5); push(16'h0102); push(16'hFFFF);
    push(16'h1234); push(16'h8000); push(16'h00FF);
    tx_ready = 1'b1;
    b0 = bytes.size(); r0 = rd_cnt; d0 = done_cnt;
    pulse_start();
    run_frame(1'b0, -1, b0, res);
    chk("s6_finished", res, 1);
    step();
    check_frame("s6", b0, r0, d0, head);
    chk("s6_first_byte", bytes[b0], 8'h00);
    chk("s6_second_byte", bytes[b0 + 1], 8'h06);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
